video_pattern_checker: RTL and testbench

- Sink-side consumer of the 24-bit pixel stream produced under the VideoReady pull handshake.
- Issues VideoReady to pull pixels and predicts the expected banded colour pattern internally.
- Compares each transferred pixel against the prediction, counts mismatches, and reports pass/fail after a programmed pixel count.
- Sits in place of the display path in self-test builds and drives board LEDs/debug registers.

---
 rtl/video_pattern_pkg.sv | 50 +++++
 rtl/video_pattern_checker_if.sv | 12 +
 rtl/pattern_predictor.sv | 52 +++++
 rtl/video_pattern_checker.sv | 123 ++++++++++++
 tb/tb_video_pattern_checker.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/video_pattern_pkg.sv
// rtl/video_pattern_pkg.sv - shared colour constants, types and helpers for the banded video test pattern
// Contents: pixel width/type, the four pattern colours, default run/band geometry,
// the colour selector enum with its sequencing helpers, and the checker state enum.
package video_pattern_pkg;

  localparam int PIX_W = 24;
  typedef logic [PIX_W-1:0] pixel_t;

  localparam pixel_t TURQUOISE   = {8'd26,  8'd188, 8'd156};
  localparam pixel_t CARROT      = {8'd230, 8'd126, 8'd34};
  localparam pixel_t SUNFLOWER   = {8'd241, 8'd196, 8'd15};
  localparam pixel_t POMEGRANATE = {8'd192, 8'd57,  8'd43};

  localparam int DEF_RUN_LENGTH    = 80;
  localparam int DEF_RUNS_PER_BAND = 5;

  // bit 1 selects the band (0 = A, 1 = B), bit 0 selects the colour within the band
  typedef enum logic [1:0] {
    COL_TURQUOISE   = 2'b00,
    COL_CARROT      = 2'b01,
    COL_SUNFLOWER   = 2'b10,
    COL_POMEGRANATE = 2'b11
  } colour_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } chk_state_e;

  function automatic pixel_t colour_value(input colour_e c);
    case (c)
      COL_TURQUOISE:   return TURQUOISE;
      COL_CARROT:      return CARROT;
      COL_SUNFLOWER:   return SUNFLOWER;
      default:         return POMEGRANATE;
    endcase
  endfunction

  // Other colour of the same band
  function automatic colour_e colour_partner(input colour_e c);
    return colour_e'({c[1], ~c[0]});
  endfunction

  // First colour of the opposite band
  function automatic colour_e band_first(input colour_e c);
    return colour_e'({~c[1], 1'b0});
  endfunction

endpackage

// File: rtl/video_pattern_checker_if.sv
// rtl/video_pattern_checker_if.sv - VideoReady pull-handshake pixel link
// Signals: video (24-bit {R,G,B} from the source), video_ready (pull strobe from the sink).
// Modports: master = pixel source, slave = pixel sink/checker.
interface video_pattern_checker_if;
  import video_pattern_pkg::*;

  pixel_t video;
  logic   video_ready;

  modport master (output video, input video_ready);
  modport slave  (input video, output video_ready);
endinterface

// File: rtl/pattern_predictor.sv
// rtl/pattern_predictor.sv - run/band sequencer producing the expected banded pattern colour
// Ports: i_clk, i_rst_n (async active-low), i_clear (sync restart at TURQUOISE),
// i_advance (one pixel consumed), o_expected (colour expected for the current pixel).
module pattern_predictor
  import video_pattern_pkg::*;
#(
  parameter int RUN_LENGTH    = DEF_RUN_LENGTH,
  parameter int RUNS_PER_BAND = DEF_RUNS_PER_BAND
) (
  input  logic   i_clk,
  input  logic   i_rst_n,
  input  logic   i_clear,
  input  logic   i_advance,
  output pixel_t o_expected
);

  localparam int RUN_W  = ($clog2(RUN_LENGTH) > 7) ? $clog2(RUN_LENGTH) : 7;
  localparam int BAND_W = ($clog2(RUNS_PER_BAND) > 3) ? $clog2(RUNS_PER_BAND) : 3;

  logic [RUN_W-1:0]  r_run_cnt;
  logic [BAND_W-1:0] r_band_run;
  colour_e           r_colour;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_run_cnt  <= '0;
      r_band_run <= '0;
      r_colour   <= COL_TURQUOISE;
    end else if (i_clear) begin
      r_run_cnt  <= '0;
      r_band_run <= '0;
      r_colour   <= COL_TURQUOISE;
    end else if (i_advance) begin
      if (r_run_cnt == RUN_W'(RUN_LENGTH - 1)) begin
        r_run_cnt <= '0;
        // End of a run: either swap within the band or hop to the other band's first colour
        if (r_band_run == BAND_W'(RUNS_PER_BAND - 1)) begin
          r_band_run <= '0;
          r_colour   <= band_first(r_colour);
        end else begin
          r_band_run <= r_band_run + 1'b1;
          r_colour   <= colour_partner(r_colour);
        end
      end else begin
        r_run_cnt <= r_run_cnt + 1'b1;
      end
    end
  end

  assign o_expected = colour_value(r_colour);

endmodule

// File: rtl/video_pattern_checker.sv
// rtl/video_pattern_checker.sv - pulls pixels with VideoReady and checks them against the banded pattern
// Ports: i_clk, i_rst_n (async active-low), i_start (begin test pulse), vid (slave link:
// video in, video_ready out), o_busy, o_done, o_pass, o_error_count (saturating),
// o_first_error_index, o_first_error_pixel.
module video_pattern_checker
  import video_pattern_pkg::*;
#(
  parameter int RUN_LENGTH    = DEF_RUN_LENGTH,
  parameter int RUNS_PER_BAND = DEF_RUNS_PER_BAND,
  parameter int TEST_PIXELS   = 8000,
  parameter int READY_PERIOD  = 1
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_start,
  video_pattern_checker_if.slave  vid,
  output logic                    o_busy,
  output logic                    o_done,
  output logic                    o_pass,
  output logic [15:0]             o_error_count,
  output logic [15:0]             o_first_error_index,
  output pixel_t                  o_first_error_pixel
);

  localparam int THR_W = (READY_PERIOD > 1) ? $clog2(READY_PERIOD) : 1;

  chk_state_e       r_state;
  logic [15:0]      r_pix_idx;
  logic [THR_W-1:0] r_throttle;
  logic             r_ready;
  logic             r_busy;
  logic             r_done;
  logic             r_pass;
  logic [15:0]      r_err_cnt;
  logic [15:0]      r_first_idx;
  pixel_t           r_first_pix;

  pixel_t           w_expected;
  logic             w_start_go;
  logic             w_mismatch;
  logic             w_last;
  logic [15:0]      w_err_next;
  logic [THR_W-1:0] w_thr_next;

  // r_ready is only ever high in RUN, so it doubles as the transfer qualifier
  assign w_start_go = i_start && (r_state != ST_RUN);
  assign w_mismatch = r_ready && (vid.video != w_expected);
  assign w_last     = r_ready && (r_pix_idx == 16'(TEST_PIXELS - 1));
  assign w_err_next = (w_mismatch && (r_err_cnt != 16'hFFFF)) ? r_err_cnt + 16'd1 : r_err_cnt;
  assign w_thr_next = (r_throttle == THR_W'(READY_PERIOD - 1)) ? '0 : r_throttle + 1'b1;

  pattern_predictor #(
    .RUN_LENGTH    (RUN_LENGTH),
    .RUNS_PER_BAND (RUNS_PER_BAND)
  ) u_predictor (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_clear    (w_start_go),
    .i_advance  (r_ready),
    .o_expected (w_expected)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= ST_IDLE;
      r_pix_idx   <= '0;
      r_throttle  <= '0;
      r_ready     <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_pass      <= 1'b0;
      r_err_cnt   <= '0;
      r_first_idx <= '0;
      r_first_pix <= '0;
    end else begin
      case (r_state)
        ST_RUN: begin
          // Throttle holds the phase of the current cycle; ready is pre-computed for the next one
          r_throttle <= w_thr_next;
          r_ready    <= (w_thr_next == '0) && !w_last;
          if (r_ready) begin
            r_err_cnt <= w_err_next;
            if (w_mismatch && (r_err_cnt == 16'd0)) begin
              r_first_idx <= r_pix_idx;
              r_first_pix <= vid.video;
            end
            r_pix_idx <= r_pix_idx + 16'd1;
          end
          if (w_last) begin
            r_state <= ST_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_pass  <= (w_err_next == 16'd0);
          end
        end
        default: begin
          // IDLE and DONE share the restart path
          if (w_start_go) begin
            r_state     <= ST_RUN;
            r_pix_idx   <= '0;
            r_throttle  <= '0;
            r_ready     <= 1'b1;
            r_busy      <= 1'b1;
            r_done      <= 1'b0;
            r_pass      <= 1'b0;
            r_err_cnt   <= '0;
            r_first_idx <= '0;
            r_first_pix <= '0;
          end
        end
      endcase
    end
  end

  assign vid.video_ready      = r_ready;
  assign o_busy               = r_busy;
  assign o_done               = r_done;
  assign o_pass               = r_pass;
  assign o_error_count        = r_err_cnt;
  assign o_first_error_index  = r_first_idx;
  assign o_first_error_pixel  = r_first_pix;

endmodule

// File: tb/tb_video_pattern_checker.sv
// tb/tb_video_pattern_checker.sv - scoreboard bench for video_pattern_checker over three configurations
module tb_video_pattern_checker;

  typedef struct {
    int          cfg;
    int          ec;
    int          fei;
    logic [23:0] fep;
    bit          pass;
    int          pulses;
  } exp_t;

  localparam int NCFG = 3;

  logic        clk;
  logic        rst_n;
  logic [2:0]  start;
  logic [2:0]  busy, done, pass, vr;
  logic [15:0] ec  [NCFG];
  logic [15:0] fei [NCFG];
  logic [23:0] fep [NCFG];

  int          n_vec = 0;
  int          n_mis = 0;
  exp_t        exp_q[$];

  int          offset    [NCFG];
  bit          const_bad [NCFG];
  logic [23:0] bad_pix [int];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int cfg_pix(input int g);
    return (g == 0) ? 800 : ((g == 1) ? 10 : 65535);
  endfunction

  function automatic int cfg_rp(input int g);
    return (g == 1) ? 3 : 1;
  endfunction

  // Ideal pattern: runs of 80, five runs per band, band A = T/C, band B = S/P
  function automatic logic [23:0] ideal_pix(input int i);
    int run, r, band;
    run  = i / 80;
    r    = run % 5;
    band = (run / 5) % 2;
    if (band == 0) return (r % 2 == 1) ? {8'd230, 8'd126, 8'd34} : {8'd26, 8'd188, 8'd156};
    else           return (r % 2 == 1) ? {8'd192, 8'd57, 8'd43}  : {8'd241, 8'd196, 8'd15};
  endfunction

  function automatic logic [23:0] src_pix(input int g, input int i);
    if (const_bad[g]) return 24'h123456;
    if (g == 0 && bad_pix.exists(i)) return bad_pix[i];
    return ideal_pix(i + offset[g]);
  endfunction

  function automatic exp_t model(input int g, input int n, input int base);
    exp_t e;
    logic [23:0] rx;
    e.cfg = g; e.ec = 0; e.fei = 0; e.fep = '0; e.pulses = n;
    for (int i = 0; i < n; i++) begin
      rx = src_pix(g, base + i);
      if (rx != ideal_pix(i)) begin
        if (e.ec == 0) begin e.fei = i; e.fep = rx; end
        if (e.ec < 65535) e.ec++;
      end
    end
    e.pass = (e.ec == 0);
    return e;
  endfunction

  task automatic chk(input string nm, input longint act, input longint exp);
    n_vec++;
    if (act != exp) begin
      n_mis++;
      $display("FAIL %s: got %0h, want %0h", nm, act, exp);
    end
  endtask

  for (genvar g = 0; g < NCFG; g++) begin : g_cfg
    video_pattern_checker_if vif ();
    logic [23:0] vid_r;
    int          src_idx;
    int          pulses, since;
    bit          seen, gap_err;
    logic        prev_done;
    exp_t        e;

    video_pattern_checker #(
      .TEST_PIXELS  (cfg_pix(g)),
      .READY_PERIOD (cfg_rp(g))
    ) dut (
      .i_clk               (clk),
      .i_rst_n             (rst_n),
      .i_start             (start[g]),
      .vid                 (vif),
      .o_busy              (busy[g]),
      .o_done              (done[g]),
      .o_pass              (pass[g]),
      .o_error_count       (ec[g]),
      .o_first_error_index (fei[g]),
      .o_first_error_pixel (fep[g])
    );

    // Source: presents pixel src_idx, advances on each pulled pixel
    always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        src_idx <= 0;
        vid_r   <= src_pix(g, 0);
      end else if (vif.video_ready) begin
        src_idx <= src_idx + 1;
        vid_r   <= src_pix(g, src_idx + 1);
      end
    end
    assign vif.video = vid_r;
    assign vr[g]     = vif.video_ready;

    // Monitor: counts ready pulses and their spacing, scores each completed test
    initial begin
      pulses = 0; since = 0; seen = 0; gap_err = 0; prev_done = 1'b0;
      forever begin
        @(negedge clk);
        if (start[g] === 1'b1 && busy[g] !== 1'b1) begin
          pulses = 0; since = 0; seen = 0; gap_err = 0;
        end
        since++;
        if (vr[g] === 1'b1) begin
          if (seen && since != cfg_rp(g)) gap_err = 1;
          since = 0; seen = 1; pulses++;
        end
        if (done[g] === 1'b1 && prev_done !== 1'b1) begin
          if (exp_q.size() == 0) begin
            n_vec++; n_mis++;
            $display("FAIL cfg%0d_unexpected_done: got done, want none", g);
          end else begin
            e = exp_q.pop_front();
            chk($sformatf("cfg%0d_scoreboard_cfg", g), g, e.cfg);
            chk($sformatf("cfg%0d_error_count", g), ec[g], e.ec);
            chk($sformatf("cfg%0d_first_error_index", g), fei[g], e.fei);
            chk($sformatf("cfg%0d_first_error_pixel", g), fep[g], e.fep);
            chk($sformatf("cfg%0d_pass", g), pass[g], e.pass);
            chk($sformatf("cfg%0d_busy_at_done", g), busy[g], 0);
            chk($sformatf("cfg%0d_ready_at_done", g), vr[g], 0);
            chk($sformatf("cfg%0d_ready_pulses", g), pulses, e.pulses);
            chk($sformatf("cfg%0d_ready_spacing_err", g), gap_err, 0);
          end
        end
        prev_done = done[g];
      end
    end
  end

  task automatic do_reset();
    @(posedge clk);
    #1 rst_n = 1'b0;
    #2;
    for (int g = 0; g < NCFG; g++) begin
      chk($sformatf("rst_cfg%0d_ready", g), vr[g], 0);
      chk($sformatf("rst_cfg%0d_busy", g), busy[g], 0);
      chk($sformatf("rst_cfg%0d_done", g), done[g], 0);
      chk($sformatf("rst_cfg%0d_pass", g), pass[g], 0);
      chk($sformatf("rst_cfg%0d_error_count", g), ec[g], 0);
      chk($sformatf("rst_cfg%0d_first_index", g), fei[g], 0);
      chk($sformatf("rst_cfg%0d_first_pixel", g), fep[g], 0);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic pulse_start(input int g);
    @(posedge clk);
    #1 start[g] = 1'b1;
    @(posedge clk);
    #1 start[g] = 1'b0;
  endtask

  task automatic run_test(input int g, input int n, input int base, input bit extra_start);
    exp_t e;
    bit   got;
    e = model(g, n, base);
    exp_q.push_back(e);
    pulse_start(g);
    if (extra_start) begin
      repeat (n / 2) @(posedge clk);
      pulse_start(g);
    end
    got = 0;
    for (int c = 0; c < n * cfg_rp(g) + 50; c++) begin
      @(posedge clk);
      #1;
      if (done[g] === 1'b1) begin got = 1; break; end
    end
    chk($sformatf("cfg%0d_done_within_budget", g), got, 1);
    if (!got) exp_q.delete();
    else begin
      repeat (5) @(posedge clk);
      #1;
      chk($sformatf("cfg%0d_done_held", g), done[g], 1);
      chk($sformatf("cfg%0d_error_count_held", g), ec[g], e.ec);
      chk($sformatf("cfg%0d_no_pull_after_done", g), vr[g], 0);
    end
  endtask

  initial begin
    rst_n = 1'b1;
    start = '0;
    for (int g = 0; g < NCFG; g++) begin offset[g] = 0; const_bad[g] = 0; end
    const_bad[2] = 1;

    do_reset();
    run_test(0, 800, 0, 0);                 // ideal source

    bad_pix[85] = 24'h000000;               // corrupt a CARROT pixel
    do_reset();
    run_test(0, 800, 0, 0);
    run_test(0, 800, 800, 0);               // restart from DONE, source continues clean

    bad_pix.delete();
    offset[0] = 80;                         // source one run ahead
    do_reset();
    run_test(0, 800, 0, 0);

    for (int k = 0; k < 4; k++) begin
      logic [23:0] v;
      int nb;
      bad_pix.delete();
      offset[0] = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 799)) : 0;
      nb = $urandom_range(0, 6);
      for (int j = 0; j < nb; j++) begin
        v = 24'($urandom());
        bad_pix[$urandom_range(0, 799)] = v;
      end
      do_reset();
      run_test(0, 800, 0, k == 1);          // k==1 also pulses Start mid-run
    end

    bad_pix.delete();
    offset[0] = 0;
    do_reset();
    pulse_start(0);
    repeat (400) @(posedge clk);
    do_reset();                             // abort mid-test, outputs checked during reset
    run_test(0, 800, 0, 0);

    do_reset();
    run_test(1, 10, 0, 0);                  // throttled pull, one pixel every third cycle

    do_reset();
    run_test(2, 65535, 0, 0);               // every pixel wrong, count reaches the ceiling

    repeat (5) @(posedge clk);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
